// File: rtl/instr_index_sequencer_pkg.sv
// Shared types for instr_index_sequencer: sequencing states, default depth, index type.
// Optional duplicate-index checking is enabled by defining MAP_CHECK_EN.
package instr_index_sequencer_pkg;

    localparam int unsigned BS_DEFAULT = 16;
    localparam int unsigned IW_DEFAULT = $clog2(BS_DEFAULT);

    typedef logic [IW_DEFAULT-1:0] idx_t;

    typedef enum logic [1:0] {
        FILL,
        MAP,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/instr_index_sequencer_map_table.sv
// index_map_table: bs x iw mapping register file, identity reset, one write and one read port.
// With MAP_CHECK_EN defined, a seen-vector flags duplicate indices on o_map_err (sticky).
module index_map_table
    import instr_index_sequencer_pkg::*;
#(
    parameter int unsigned bs = BS_DEFAULT,
    localparam int unsigned iw = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [iw-1:0] i_wr_addr,
    input  logic [iw-1:0] i_wr_data,
    input  logic [iw-1:0] i_rd_addr,
    output logic [iw-1:0] o_rd_data
`ifdef MAP_CHECK_EN
    ,
    output logic          o_map_err
`endif
);

    logic [iw-1:0] r_mem [bs];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < bs; i++) begin
                r_mem[i] <= iw'(i);
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Write-through read so a slot-0 write on the FILL->MAP edge reaches the first mapped index.
    assign o_rd_data = (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];

`ifdef MAP_CHECK_EN
    logic [bs-1:0] r_seen;
    logic          r_err;
    logic [iw-1:0] w_old;
    logic          w_dup;

    assign w_old = r_mem[i_wr_addr];
    assign w_dup = (i_wr_data != w_old) && r_seen[i_wr_data];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= '1;
            r_err  <= 1'b0;
        end else if (i_wr_en) begin
            r_seen[w_old]     <= 1'b0;
            r_seen[i_wr_data] <= 1'b1;
            if (w_dup) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_map_err = r_err;
`endif

endmodule

// File: rtl/instr_index_sequencer.sv
// Issues buffer indices: linear fill, then mapped order after start, then a bs-entry drain.
// Define MAP_CHECK_EN to add the map_err duplicate-index output.
module instr_index_sequencer
    import instr_index_sequencer_pkg::*;
#(
    parameter int unsigned bs = BS_DEFAULT,
    localparam int unsigned iw = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          start,
    input  logic          stream_end,
    input  logic          map_wr_en,
    input  logic [iw-1:0] map_wr_addr,
    input  logic [iw-1:0] map_wr_data,
    output logic [iw-1:0] buffer_index,
    output logic          map_active,
    output logic          done
`ifdef MAP_CHECK_EN
    ,
    output logic          map_err
`endif
);

    seq_state_t    r_state, w_state_nxt;
    logic [iw-1:0] r_idx, w_idx_nxt;
    logic [iw-1:0] r_ptr, w_ptr_nxt;
    logic [iw-1:0] r_cnt, w_cnt_nxt;
    logic          r_map_active, r_done;
    logic [iw-1:0] w_map_data;
    logic          w_tbl_wr_en;

    assign w_tbl_wr_en = map_wr_en && (r_state == FILL);

    index_map_table #(
        .bs(bs)
    ) u_map (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_tbl_wr_en),
        .i_wr_addr (map_wr_addr),
        .i_wr_data (map_wr_data),
        .i_rd_addr (r_ptr),
        .o_rd_data (w_map_data)
`ifdef MAP_CHECK_EN
        ,
        .o_map_err (map_err)
`endif
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        if (!stall) begin
            case (r_state)
                FILL: begin
                    if (start) begin
                        w_state_nxt = MAP;
                        w_idx_nxt   = w_map_data;
                        w_ptr_nxt   = r_ptr + iw'(1);
                    end else begin
                        w_idx_nxt = r_idx + iw'(1);
                    end
                end
                MAP: begin
                    w_idx_nxt = w_map_data;
                    w_ptr_nxt = r_ptr + iw'(1);
                    if (stream_end) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = iw'(bs - 1);
                    end
                end
                DRAIN: begin
                    w_idx_nxt = w_map_data;
                    w_ptr_nxt = r_ptr + iw'(1);
                    if (r_cnt == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - iw'(1);
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_map_active <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_ptr        <= w_ptr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_map_active <= (w_state_nxt == MAP) || (w_state_nxt == DRAIN);
            r_done       <= (w_state_nxt == DONE);
        end
    end

    assign buffer_index = r_idx;
    assign map_active   = r_map_active;
    assign done         = r_done;

endmodule

// File: tb/tb_instr_index_sequencer.sv
// Self-checking bench for instr_index_sequencer (bs=4): directed scenarios plus random episodes
// compared every cycle against a behavioural model. Checks map_err when MAP_CHECK_EN is defined.
module tb_instr_index_sequencer;

    localparam int unsigned BS = 4;
    localparam int unsigned IW = $clog2(BS);

    logic          clk;
    logic          rst;
    logic          stall;
    logic          start;
    logic          stream_end;
    logic          map_wr_en;
    logic [IW-1:0] map_wr_addr;
    logic [IW-1:0] map_wr_data;
    logic [IW-1:0] buffer_index;
    logic          map_active;
    logic          done;
`ifdef MAP_CHECK_EN
    logic          map_err;
`endif

    instr_index_sequencer #(
        .bs(BS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .start        (start),
        .stream_end   (stream_end),
        .map_wr_en    (map_wr_en),
        .map_wr_addr  (map_wr_addr),
        .map_wr_data  (map_wr_data),
        .buffer_index (buffer_index),
        .map_active   (map_active),
        .done         (done)
`ifdef MAP_CHECK_EN
        ,
        .map_err      (map_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: phase flags and a remaining-issue count rather than a state machine.
    int m_map [BS];
    bit m_seen [BS];
    int m_idx, m_pos, m_left;
    bit m_in_map, m_done, m_err;

    function automatic void model_step(input bit r, input bit st, input bit s, input bit e,
                                       input bit we, input int wa, input int wd);
        bit filling;
        if (r) begin
            for (int i = 0; i < BS; i++) begin
                m_map[i]  = i;
                m_seen[i] = 1'b1;
            end
            m_idx = 0; m_pos = 0; m_left = -1;
            m_in_map = 1'b0; m_done = 1'b0; m_err = 1'b0;
            return;
        end
        filling = !m_in_map && !m_done;
        if (we && filling) begin
            if (wd != m_map[wa] && m_seen[wd]) m_err = 1'b1;
            m_seen[m_map[wa]] = 1'b0;
            m_seen[wd]        = 1'b1;
            m_map[wa]         = wd;
        end
        if (st) return;
        if (filling) begin
            if (s) begin
                m_idx = m_map[0];
                m_pos = 1;
                m_in_map = 1'b1;
            end else begin
                m_idx = (m_idx + 1) % BS;
            end
        end else if (!m_done) begin
            m_idx = m_map[m_pos];
            m_pos = (m_pos + 1) % BS;
            if (m_left < 0) begin
                if (e) m_left = BS;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_in_map = 1'b0;
                end
            end
        end
    endfunction

    task automatic tick(input bit r, input bit st, input bit s, input bit e,
                        input bit we, input int wa, input int wd);
        rst = r; stall = st; start = s; stream_end = e;
        map_wr_en = we; map_wr_addr = IW'(wa); map_wr_data = IW'(wd);
        @(posedge clk);
        model_step(r, st, s, e, we, wa, wd);
        #1;
        check_eq("buffer_index", int'(buffer_index), m_idx);
        check_eq("map_active", int'(map_active), int'(m_in_map));
        check_eq("done", int'(done), int'(m_done));
`ifdef MAP_CHECK_EN
        check_eq("map_err", int'(map_err), int'(m_err));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; start = 1'b0; stream_end = 1'b0;
        map_wr_en = 1'b0; map_wr_addr = '0; map_wr_data = '0;

        // Linear fill with wrap.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        idle(6);

        // Reverse map, mapped issue, stall mid-MAP, drain and hold.
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < BS; i++) tick(0, 0, 0, 0, 1, i, BS - 1 - i);
        tick(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        tick(0, 1, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 1, 0, 0, 0);
        idle(2);
        tick(0, 0, 0, 1, 0, 0, 0);
        idle(BS + 3);

        // Write in MAP ignored; identity order.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 2);
        idle(BS + 1);

        // Slot-0 write on the start edge is used for the first mapped index.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 1, 0, 3);
        idle(BS);

        // Duplicate write sets sticky error (observed only with the check enabled).
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 1, 0);
        idle(3);

        // Reset during DRAIN restores identity table.
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 2);
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        idle(BS);

        // Random episodes.
        for (int ep = 0; ep < 25; ep++) begin
            tick(1, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 45; c++) begin
                tick($urandom_range(0, 59) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, BS - 1)),
                     int'($urandom_range(0, BS - 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
